// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for the MIPS-subset datapath.
// Sequences FETCH -> DECODE -> EXEC -> WB for ALU ops.
// Sequences FETCH -> DECODE -> BRANCH for BEQ.
// Unsupported instructions park in a sticky ILLEGAL state until reset.
// Optional feature macro: MC_CTRL_RETIRE_CNT_EN builds the retired-instruction counter.
// Without the macro, retired is tied to zero.
module mc_ctrl_fsm #(
  parameter logic [5:0]  OPC_RTYPE = 6'h00,
  parameter logic [5:0]  OPC_ADDI  = 6'h08,
  parameter logic [5:0]  OPC_BEQ   = 6'h04,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             ir_load,
  output logic             pc_load,
  output logic             pc_src,
  output logic             rd_mux_s,
  output logic             op2_mux_s,
  output logic             write,
  output logic [5:0]       alu_funct,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StWb,
    StBranch,
    StIllegal
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] opc_r_q, opc_r_d;
  logic [5:0] fn_r_q, fn_r_d;
  logic       illegal_q, illegal_d;
  logic       rtype_ok;
  logic       is_addi;

  // Supported R-type functs: add, sub, and, or, slt.
  always_comb begin
    rtype_ok = 1'b0;
    unique case (funct)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: rtype_ok = 1'b1;
      default:                           rtype_ok = 1'b0;
    endcase
  end

  assign is_addi = (opc_r_q == OPC_ADDI);

  // State and latched-instruction registers; reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StFetch;
      opc_r_q   <= 6'h00;
      fn_r_q    <= 6'h00;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_r_q   <= opc_r_d;
      fn_r_q    <= fn_r_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic; opcode/funct are only consulted in DECODE.
  always_comb begin
    state_d   = state_q;
    opc_r_d   = opc_r_q;
    fn_r_d    = fn_r_q;
    illegal_d = illegal_q;
    unique case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        opc_r_d = opcode;
        fn_r_d  = funct;
        if (opcode == OPC_BEQ) begin
          state_d = StBranch;
        end else if (opcode == OPC_ADDI) begin
          state_d = StExec;
        end else if (opcode == OPC_RTYPE && rtype_ok) begin
          state_d = StExec;
        end else begin
          state_d   = StIllegal;
          illegal_d = 1'b1;
        end
      end
      StExec:    state_d = StWb;
      StWb:      state_d = StFetch;
      StBranch:  state_d = StFetch;
      StIllegal: state_d = StIllegal;
      default:   state_d = StFetch;
    endcase
  end

  // Moore outputs from state and latched instruction; zero feeds pc_src only.
  always_comb begin
    ir_load   = 1'b0;
    pc_load   = 1'b0;
    pc_src    = 1'b0;
    rd_mux_s  = 1'b0;
    op2_mux_s = 1'b0;
    write     = 1'b0;
    alu_funct = 6'h00;
    unique case (state_q)
      StFetch: ir_load = 1'b1;
      StExec, StWb: begin
        if (is_addi) begin
          alu_funct = 6'h20;
          op2_mux_s = 1'b1;
        end else begin
          alu_funct = fn_r_q;
          rd_mux_s  = 1'b1;
        end
        if (state_q == StWb) begin
          write   = 1'b1;
          pc_load = 1'b1;
        end
      end
      StBranch: begin
        alu_funct = 6'h22;
        pc_load   = 1'b1;
        pc_src    = zero;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;

`ifdef MC_CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q, retired_d;

  // Count one retire in WB or BRANCH; wraps silently.
  always_comb begin
    retired_d = retired_q;
    if (state_q == StWb || state_q == StBranch) begin
      retired_d = retired_q + 1'b1;
    end
  end

  // Retired counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm with CNT_W=4 so the retired counter wraps quickly.
module tb_mc_ctrl_fsm;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       ir_load, pc_load, pc_src, rd_mux_s, op2_mux_s, write, illegal;
  logic [5:0] alu_funct;
  logic [3:0] retired;

  int         vectors    = 0;
  int         miscompares = 0;
  logic [3:0] model_ret  = 4'd0;

  mc_ctrl_fsm #(
    .CNT_W(4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .opcode   (opcode),
    .funct    (funct),
    .zero     (zero),
    .ir_load  (ir_load),
    .pc_load  (pc_load),
    .pc_src   (pc_src),
    .rd_mux_s (rd_mux_s),
    .op2_mux_s(op2_mux_s),
    .write    (write),
    .alu_funct(alu_funct),
    .illegal  (illegal),
    .retired  (retired)
  );

  always #5 clock = ~clock;

  logic [12:0] obs;
  assign obs = {ir_load, pc_load, pc_src, rd_mux_s, op2_mux_s, write, alu_funct, illegal};

  function automatic logic [12:0] pk(input logic ir, input logic pcl, input logic pcs,
                                     input logic rd, input logic op2, input logic wr,
                                     input logic [5:0] alu, input logic ill);
    return {ir, pcl, pcs, rd, op2, wr, alu, ill};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [12:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ret(input string tag);
    logic [3:0] exp;
`ifdef MC_CTRL_RETIRE_CNT_EN
    exp = model_ret;
`else
    exp = 4'd0;
`endif
    vectors++;
    assert (retired === exp)
    else begin
      miscompares++;
      $error("FAIL %s: retired observed %0d expected %0d", tag, retired, exp);
    end
  endtask

  // Entered and left with the FSM in FETCH, sampled 1ns after the edge.
  task automatic run_alu(input string tag, input logic [5:0] opc, input logic [5:0] fn,
                         input logic [5:0] alu, input logic rd, input logic op2);
    opcode = opc;
    funct  = fn;
    chk({tag, "_fetch"}, pk(1, 0, 0, 0, 0, 0, 6'h00, 0));
    tick();
    chk({tag, "_decode"}, pk(0, 0, 0, 0, 0, 0, 6'h00, 0));
    tick();
    chk({tag, "_exec"}, pk(0, 0, 0, rd, op2, 0, alu, 0));
    tick();
    chk({tag, "_wb"}, pk(0, 1, 0, rd, op2, 1, alu, 0));
    model_ret++;
    tick();
    chk_ret({tag, "_retired"});
  endtask

  task automatic run_beq(input string tag, input logic z);
    opcode = 6'h04;
    funct  = 6'h00;
    zero   = z;
    chk({tag, "_fetch"}, pk(1, 0, 0, 0, 0, 0, 6'h00, 0));
    tick();
    chk({tag, "_decode"}, pk(0, 0, 0, 0, 0, 0, 6'h00, 0));
    tick();
    chk({tag, "_branch"}, pk(0, 1, z, 0, 0, 0, 6'h22, 0));
    model_ret++;
    tick();
    chk_ret({tag, "_retired"});
    zero = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_ret = 4'd0;
  endtask

  task automatic run_illegal(input string tag, input logic [5:0] opc, input logic [5:0] fn);
    opcode = opc;
    funct  = fn;
    chk({tag, "_fetch"}, pk(1, 0, 0, 0, 0, 0, 6'h00, 0));
    tick();
    chk({tag, "_decode"}, pk(0, 0, 0, 0, 0, 0, 6'h00, 0));
    tick();
    chk({tag, "_trap"}, pk(0, 0, 0, 0, 0, 0, 6'h00, 1));
    opcode = 6'h08;
    repeat (3) tick();
    chk({tag, "_sticky"}, pk(0, 0, 0, 0, 0, 0, 6'h00, 1));
    chk_ret({tag, "_noretire"});
    do_reset();
    chk({tag, "_cleared"}, pk(1, 0, 0, 0, 0, 0, 6'h00, 0));
    chk_ret({tag, "_cleared_ret"});
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 6'h00;
    funct  = 6'h00;
    zero   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_state", pk(1, 0, 0, 0, 0, 0, 6'h00, 0));
    chk_ret("reset_retired");

    run_alu("add", 6'h00, 6'h20, 6'h20, 1, 0);
    run_alu("addi", 6'h08, 6'h3F, 6'h20, 0, 1);
    run_alu("sub", 6'h00, 6'h22, 6'h22, 1, 0);
    run_alu("and", 6'h00, 6'h24, 6'h24, 1, 0);
    run_alu("or", 6'h00, 6'h25, 6'h25, 1, 0);
    run_alu("slt", 6'h00, 6'h2A, 6'h2A, 1, 0);
    run_beq("beq_taken", 1'b1);
    run_beq("beq_not", 1'b0);

    run_illegal("bad_funct", 6'h00, 6'h3F);
    run_illegal("bad_opc", 6'h3F, 6'h20);

    // Reset during EXEC: FETCH next and no write pulse.
    opcode = 6'h00;
    funct  = 6'h20;
    tick();
    tick();
    chk("mid_exec", pk(0, 0, 0, 1, 0, 0, 6'h20, 0));
    do_reset();
    chk("mid_reset_fetch", pk(1, 0, 0, 0, 0, 0, 6'h00, 0));
    chk_ret("mid_reset_ret");
    tick();
    chk("mid_reset_decode", pk(0, 0, 0, 0, 0, 0, 6'h00, 0));
    do_reset();

    // Sixteen retires wrap a 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) run_beq("wrap_beq", i[2]);
      else run_alu("wrap_addi", 6'h08, 6'h00, 6'h20, 0, 1);
    end
    chk_ret("wrap_zero");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
